// File: rtl/operand_fetch_pkg.sv
// Shared widths and enumerations for the operand-fetch stage and its forwarding muxes.
package operand_fetch_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;
  localparam int CNT_W    = 16;

  typedef enum logic {EMPTY, FULL} state_t;
  typedef enum logic [1:0] {FWD_RF, FWD_EX, FWD_MEM} fwd_src_t;
endpackage

// File: rtl/operand_fetch_fwd_select.sv
// Per-source bypass selection: picks ex, mem or register-file data and flags a load-use hazard.
module fwd_select
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = operand_fetch_pkg::DATA_W,
  parameter int ADDR_W = operand_fetch_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] idx,
  input  logic              use_src,
  input  logic              ex_wb,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_wb,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] operand,
  output fwd_src_t          src,
  output logic              hazard
);
  // A load still in execute has no data yet, so it never bypasses; it raises a hazard instead.
  always_comb begin
    src = FWD_RF;
    if (use_src && ex_wb && !ex_is_load && (ex_rd == idx))
      src = FWD_EX;
    else if (use_src && mem_wb && (mem_rd == idx))
      src = FWD_MEM;
  end

  always_comb begin
    operand = rf_data;
    case (src)
      FWD_EX:  operand = ex_result;
      FWD_MEM: operand = mem_result;
      default: operand = rf_data;
    endcase
  end

  assign hazard = use_src && ex_wb && ex_is_load && (ex_rd == idx);
endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register-file selects, bypass resolution, load-use stall and a
// one-entry valid/ready output register feeding execute.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = operand_fetch_pkg::DATA_W,
  parameter int ADDR_W = operand_fetch_pkg::ADDR_W,
  parameter int CNT_W  = operand_fetch_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rn,
  input  logic [ADDR_W-1:0] in_rm,
  input  logic              in_use_rn,
  input  logic              in_use_rm,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wb,
  input  logic              in_is_load,
  output logic [ADDR_W-1:0] rf_sel_a,
  output logic [ADDR_W-1:0] rf_sel_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  input  logic              ex_wb,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_wb,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wb,
  output logic              out_is_load,
  output logic [CNT_W-1:0]  stall_count
);
  state_t            state;
  logic [DATA_W-1:0] opnd_a, opnd_b;
  logic              haz_a, haz_b, hazard, accept;
  fwd_src_t          unused_src_a, unused_src_b;

  assign rf_sel_a = in_rn;
  assign rf_sel_b = in_rm;

  fwd_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
    .idx(in_rn), .use_src(in_use_rn),
    .ex_wb(ex_wb), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_wb(mem_wb), .mem_rd(mem_rd), .mem_result(mem_result),
    .rf_data(rf_data_a), .operand(opnd_a), .src(unused_src_a), .hazard(haz_a)
  );

  fwd_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
    .idx(in_rm), .use_src(in_use_rm),
    .ex_wb(ex_wb), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_wb(mem_wb), .mem_rd(mem_rd), .mem_result(mem_result),
    .rf_data(rf_data_b), .operand(opnd_b), .src(unused_src_b), .hazard(haz_b)
  );

  assign hazard    = in_valid && (haz_a || haz_b);
  assign in_ready  = !hazard && !flush && ((state == EMPTY) || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      out_a       <= '0;
      out_b       <= '0;
      out_rd      <= '0;
      out_wb      <= 1'b0;
      out_is_load <= 1'b0;
      stall_count <= '0;
    end else begin
      // Counts stalls regardless of flush; saturates rather than wrapping.
      if (hazard && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (flush) begin
        state <= EMPTY;
      end else if (accept) begin
        state       <= FULL;
        out_a       <= opnd_a;
        out_b       <= opnd_b;
        out_rd      <= in_rd;
        out_wb      <= in_wb;
        out_is_load <= in_is_load;
      end else if ((state == FULL) && out_ready) begin
        state <= EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: vector table, hand-written corner sequences and random traffic
// against a cycle-level reference model.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [3:0]  in_rn, in_rm, in_rd, rf_sel_a, rf_sel_b, ex_rd, mem_rd, out_rd;
  logic        in_use_rn, in_use_rm, in_wb, in_is_load;
  logic [31:0] rf_data_a, rf_data_b, ex_result, mem_result, out_a, out_b;
  logic        ex_wb, ex_is_load, mem_wb, out_valid, out_ready, out_wb, out_is_load;
  logic [15:0] stall_count;

  int checks = 0;
  int failures = 0;

  bit          m_full;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_rd;
  logic        m_wb, m_ld;
  int          m_stall;

  logic [31:0] sa, sb;
  logic [3:0]  srd;

  typedef struct {
    logic [3:0]  rn, rm;
    logic        use_rn, use_rm;
    logic [31:0] rf_a, rf_b;
    logic        ex_wb, ex_ld;
    logic [3:0]  ex_rd;
    logic [31:0] ex_res;
    logic        mem_wb;
    logic [3:0]  mem_rd;
    logic [31:0] mem_res;
    logic [31:0] exp_a, exp_b;
  } vec_t;
  vec_t vecs[9];

  operand_fetch dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rn(in_rn), .in_rm(in_rm), .in_use_rn(in_use_rn), .in_use_rm(in_use_rm),
    .in_rd(in_rd), .in_wb(in_wb), .in_is_load(in_is_load),
    .rf_sel_a(rf_sel_a), .rf_sel_b(rf_sel_b), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .ex_wb(ex_wb), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_wb(mem_wb), .mem_rd(mem_rd), .mem_result(mem_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_rd(out_rd), .out_wb(out_wb), .out_is_load(out_is_load), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bypass rule: youngest non-load producer in ex wins, then mem, else the register file.
  function automatic logic [31:0] resolve(logic [3:0] idx, logic use_src, logic [31:0] rf);
    if (!use_src) return rf;
    if (ex_wb && !ex_is_load && ex_rd == idx) return ex_result;
    if (mem_wb && mem_rd == idx) return mem_result;
    return rf;
  endfunction

  task automatic cycle();
    logic haz, exp_rdy, acc;
    logic [31:0] na, nb;
    #1;
    haz = in_valid && ex_wb && ex_is_load &&
          ((in_use_rn && in_rn == ex_rd) || (in_use_rm && in_rm == ex_rd));
    exp_rdy = !haz && !flush && (!m_full || out_ready);
    chk("in_ready", in_ready, exp_rdy);
    chk("rf_sel_a", rf_sel_a, in_rn);
    chk("rf_sel_b", rf_sel_b, in_rm);
    na  = resolve(in_rn, in_use_rn, rf_data_a);
    nb  = resolve(in_rm, in_use_rm, rf_data_b);
    acc = in_valid && exp_rdy;
    @(posedge clk);
    if (reset) begin
      m_full = 0; m_a = 0; m_b = 0; m_rd = 0; m_wb = 0; m_ld = 0; m_stall = 0;
    end else begin
      if (haz && m_stall < 65535) m_stall++;
      if (flush) m_full = 0;
      else if (acc) begin
        m_full = 1; m_a = na; m_b = nb; m_rd = in_rd; m_wb = in_wb; m_ld = in_is_load;
      end else if (out_ready) m_full = 0;
    end
    #1;
    chk("out_valid", out_valid, m_full);
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("out_rd", out_rd, m_rd);
    chk("out_wb", out_wb, m_wb);
    chk("out_is_load", out_is_load, m_ld);
    chk("stall_count", stall_count, m_stall);
  endtask

  task automatic quiet_inputs();
    flush = 0; in_valid = 0; in_rn = 0; in_rm = 0; in_use_rn = 0; in_use_rm = 0;
    in_rd = 0; in_wb = 0; in_is_load = 0; rf_data_a = 0; rf_data_b = 0;
    ex_wb = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
    mem_wb = 0; mem_rd = 0; mem_result = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  initial begin
    vecs[0] = '{4'd3, 4'd5, 1'b1, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    32'h11,   32'h22};
    vecs[1] = '{4'd3, 4'd5, 1'b1, 1'b1, 32'h11, 32'h22, 1'b1, 1'b0, 4'd3, 32'hAAAA, 1'b1, 4'd3, 32'hBBBB, 32'hAAAA, 32'h22};
    vecs[2] = '{4'd3, 4'd5, 1'b1, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 4'd3, 32'hAAAA, 1'b1, 4'd3, 32'hBBBB, 32'hBBBB, 32'h22};
    vecs[3] = '{4'd3, 4'd7, 1'b1, 1'b0, 32'h11, 32'h33, 1'b1, 1'b1, 4'd7, 32'hAAAA, 1'b0, 4'd0, 32'h0,    32'h11,   32'h33};
    vecs[4] = '{4'd5, 4'd5, 1'b0, 1'b1, 32'h11, 32'h22, 1'b1, 1'b0, 4'd5, 32'hCC,   1'b1, 4'd5, 32'hDD,   32'h11,   32'hCC};
    vecs[5] = '{4'd0, 4'd0, 1'b1, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 4'd0, 32'h0,    1'b1, 4'd0, 32'h77,   32'h77,   32'h77};
    vecs[6] = '{4'd3, 4'd5, 1'b1, 1'b1, 32'h44, 32'h55, 1'b1, 1'b0, 4'd9, 32'hAAAA, 1'b0, 4'd3, 32'hBBBB, 32'h44,   32'h55};
    vecs[7] = '{4'd3, 4'd5, 1'b1, 1'b1, 32'h66, 32'h88, 1'b0, 1'b1, 4'd3, 32'hAAAA, 1'b1, 4'd4, 32'hBBBB, 32'h66,   32'h88};
    vecs[8] = '{4'd7, 4'd2, 1'b1, 1'b0, 32'h12, 32'h34, 1'b1, 1'b1, 4'd2, 32'hAAAA, 1'b1, 4'd7, 32'h5,    32'h5,    32'h34};

    quiet_inputs();
    in_valid = 1; in_rn = 3; in_rm = 5; in_use_rn = 1; in_use_rm = 1; in_wb = 1;
    rf_data_a = 32'hDEAD; rf_data_b = 32'hBEEF;
    reset = 1;
    cycle();
    cycle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_stall", stall_count, 0);
    reset = 0;
    quiet_inputs();

    // Table: one accepted instruction per cycle, back to back.
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; out_ready = 1; flush = 0; in_rd = 4'(i); in_wb = 1; in_is_load = 0;
      in_rn = vecs[i].rn; in_rm = vecs[i].rm;
      in_use_rn = vecs[i].use_rn; in_use_rm = vecs[i].use_rm;
      rf_data_a = vecs[i].rf_a; rf_data_b = vecs[i].rf_b;
      ex_wb = vecs[i].ex_wb; ex_is_load = vecs[i].ex_ld; ex_rd = vecs[i].ex_rd;
      ex_result = vecs[i].ex_res;
      mem_wb = vecs[i].mem_wb; mem_rd = vecs[i].mem_rd; mem_result = vecs[i].mem_res;
      cycle();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_a", i), out_a, vecs[i].exp_a);
      chk($sformatf("vec%0d_b", i), out_b, vecs[i].exp_b);
      chk($sformatf("vec%0d_rd", i), out_rd, i);
    end

    // Load-use: one stall, then the load result arrives from mem.
    quiet_inputs();
    do_reset();
    in_valid = 1; in_rn = 1; in_rm = 7; in_use_rn = 1; in_use_rm = 1; in_rd = 2; in_wb = 1;
    rf_data_a = 32'h10; rf_data_b = 32'h20;
    ex_wb = 1; ex_is_load = 1; ex_rd = 7;
    #1 chk("lu_ready", in_ready, 0);
    cycle();
    chk("lu_stall1", stall_count, 1);
    chk("lu_not_valid", out_valid, 0);
    ex_wb = 0; ex_is_load = 0; mem_wb = 1; mem_rd = 7; mem_result = 32'h5;
    cycle();
    chk("lu_valid", out_valid, 1);
    chk("lu_out_b", out_b, 32'h5);
    chk("lu_stall_hold", stall_count, 1);
    ex_wb = 1; ex_is_load = 1; ex_rd = 7; in_use_rm = 0; rf_data_b = 32'h99;
    cycle();
    chk("lu_unused_stall", stall_count, 1);
    chk("lu_unused_b", out_b, 32'h99);

    // Backpressure for three cycles, then back-to-back transfers.
    quiet_inputs();
    in_valid = 1; in_rn = 4; in_rm = 6; in_use_rn = 1; in_use_rm = 1; in_rd = 9;
    rf_data_a = 32'hA1; rf_data_b = 32'hB1;
    cycle();
    sa = out_a; sb = out_b; srd = out_rd;
    out_ready = 0; rf_data_a = 32'hA2; rf_data_b = 32'hB2; in_rd = 10;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", in_ready, 0);
      cycle();
      chk("bp_valid", out_valid, 1);
      chk("bp_a", out_a, sa);
      chk("bp_b", out_b, sb);
      chk("bp_rd", out_rd, srd);
    end
    out_ready = 1; rf_data_a = 32'h1234;
    cycle();
    chk("b2b_a1", out_a, 32'h1234);
    rf_data_a = 32'h5678;
    cycle();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_a2", out_a, 32'h5678);

    // Flush while full, with and without downstream ready; then reset mid-transfer.
    flush = 1; out_ready = 0;
    #1 chk("fl_ready", in_ready, 0);
    cycle();
    chk("fl_valid", out_valid, 0);
    flush = 0; out_ready = 1;
    cycle();
    flush = 1;
    cycle();
    chk("fl_or_valid", out_valid, 0);
    flush = 0;
    cycle();
    reset = 1;
    cycle();
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_a", out_a, 0);
    reset = 0;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 299) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_rn      = 4'($urandom_range(0, 3));
      in_rm      = 4'($urandom_range(0, 3));
      in_use_rn  = ($urandom_range(0, 3) != 0);
      in_use_rm  = ($urandom_range(0, 3) != 0);
      in_rd      = 4'($urandom);
      in_wb      = 1'($urandom);
      in_is_load = 1'($urandom);
      rf_data_a  = $urandom;
      rf_data_b  = $urandom;
      ex_wb      = 1'($urandom);
      ex_is_load = ($urandom_range(0, 2) == 0);
      ex_rd      = 4'($urandom_range(0, 3));
      ex_result  = $urandom;
      mem_wb     = 1'($urandom);
      mem_rd     = 4'($urandom_range(0, 3));
      mem_result = $urandom;
      out_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Saturation of the stall counter under a held hazard.
    quiet_inputs();
    do_reset();
    in_valid = 1; in_rn = 2; in_use_rn = 1; ex_wb = 1; ex_is_load = 1; ex_rd = 2;
    for (int n = 0; n < 65536 + 5; n++) cycle();
    chk("stall_sat", stall_count, 32'hFFFF);
    flush = 1;
    cycle();
    chk("stall_sat_flush", stall_count, 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
